// File: rtl/md_sequencer.sv
// Iterative multiply/divide unit beside the EX-stage ALU. Owns HI/LO and stalls the pipeline
// for WIDTH+2 cycles per operation (WIDTH shift steps, one sign-fix cycle, one start cycle).
module md_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_EX,
    input  logic [1:0]       mdOp_EX,
    input  logic [WIDTH-1:0] operandA_EX,
    input  logic [WIDTH-1:0] operandB_EX,
    output logic             stall_md,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divByZero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

    state_e           r_state;
    logic [1:0]       r_op;
    logic             r_signA;
    logic             r_signB;
    logic             r_dz;
    logic [WIDTH-1:0] r_rawA;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;
    logic             r_busy;

    // mdOp_EX[0]=0 selects the signed variant; mdOp_EX[1]=1 selects divide.
    logic             w_signA;
    logic             w_signB;
    logic [WIDTH-1:0] w_magA;
    logic [WIDTH-1:0] w_magB;

    assign w_signA = ~mdOp_EX[0] & operandA_EX[WIDTH-1];
    assign w_signB = ~mdOp_EX[0] & operandB_EX[WIDTH-1];
    assign w_magA  = w_signA ? (~operandA_EX + 1'b1) : operandA_EX;
    assign w_magB  = w_signB ? (~operandB_EX + 1'b1) : operandB_EX;

    // Multiply step: {acc,q} holds the partial product, q shifts the multiplier out LSB first.
    logic [WIDTH:0]   w_sum;
    assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH + 1){1'b0}});

    // Restoring divide step; remainder < divisor keeps the trial within WIDTH+1 signed bits.
    logic [WIDTH:0]   w_trial;
    logic             w_trial_neg;
    assign w_trial     = {r_acc, r_q[WIDTH-1]} - {1'b0, r_b};
    assign w_trial_neg = w_trial[WIDTH];

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;

    assign w_prod     = {r_acc, r_q};
    assign w_prod_neg = ~w_prod + 1'b1;

    always_comb begin
        w_hi_fix = r_hi;
        w_lo_fix = r_lo;
        if (!r_op[1]) begin
            {w_hi_fix, w_lo_fix} = (r_signA ^ r_signB) ? w_prod_neg : w_prod;
        end else if (r_dz) begin
            w_lo_fix = {WIDTH{1'b1}};
            w_hi_fix = r_rawA;
        end else begin
            w_lo_fix = (r_signA ^ r_signB) ? (~r_q + 1'b1) : r_q;
            w_hi_fix = r_signA ? (~r_acc + 1'b1) : r_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_op    <= 2'b00;
            r_signA <= 1'b0;
            r_signB <= 1'b0;
            r_dz    <= 1'b0;
            r_rawA  <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_dbz <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start_EX) begin
                        r_op    <= mdOp_EX;
                        r_signA <= w_signA;
                        r_signB <= w_signB;
                        r_dz    <= mdOp_EX[1] & (operandB_EX == '0);
                        r_rawA  <= operandA_EX;
                        r_acc   <= '0;
                        r_q     <= w_magA;
                        r_b     <= w_magB;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StCalc;
                    end
                end
                StCalc: begin
                    if (!r_op[1]) begin
                        r_acc <= w_sum[WIDTH:1];
                        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                    end else if (!w_trial_neg) begin
                        r_acc <= w_trial[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CntLast) begin
                        r_state <= StFix;
                    end
                end
                StFix: begin
                    r_hi    <= w_hi_fix;
                    r_lo    <= w_lo_fix;
                    r_dbz   <= r_op[1] & r_dz;
                    r_state <= StDone;
                end
                StDone: begin
                    // start_EX here belongs to the instruction that just finished.
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign stall_md  = ((r_state == StIdle) & start_EX) | (r_state == StCalc)
                     | (r_state == StFix);
    assign busy      = r_busy;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign divByZero = r_dbz;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed corner cases plus randomized ops against a
// reference model built on 64-bit arithmetic.
module tb_md_sequencer;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start_EX;
    logic [1:0]       mdOp_EX;
    logic [WIDTH-1:0] operandA_EX;
    logic [WIDTH-1:0] operandB_EX;
    logic             stall_md;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divByZero;

    md_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_EX   (start_EX),
        .mdOp_EX    (mdOp_EX),
        .operandA_EX(operandA_EX),
        .operandB_EX(operandB_EX),
        .stall_md   (stall_md),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo),
        .divByZero  (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint sr;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        e.dz = 1'b0;
        case (op)
            2'b00: begin
                sr = sa * sb;
                ur = 64'(sr);
                e.hi = ur[63:32];
                e.lo = ur[31:0];
            end
            2'b01: begin
                ur = ua * ub;
                e.hi = ur[63:32];
                e.lo = ur[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    e.dz = 1'b1;
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else if (op == 2'b10) begin
                    sr = sa / sb;
                    ur = 64'(sr);
                    e.lo = ur[31:0];
                    sr = sa % sb;
                    ur = 64'(sr);
                    e.hi = ur[31:0];
                end else begin
                    ur = ua / ub;
                    e.lo = ur[31:0];
                    ur = ua % ub;
                    e.hi = ur[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: DONE is the only cycle with busy high and stall low.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
        end else if (busy && !stall_md) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got result hi=0x%08h lo=0x%08h expected none",
                         hi, lo);
            end else begin
                e = exp_q.pop_front();
                m_hi = e.hi;
                m_lo = e.lo;
                check("done_hi", hi, e.hi);
                check("done_lo", lo, e.lo);
                check("done_divByZero", {31'h0, divByZero}, {31'h0, e.dz});
            end
        end else begin
            check("hold_hi", hi, m_hi);
            check("hold_lo", lo, m_lo);
            check("idle_divByZero", {31'h0, divByZero}, 32'h0);
        end
    end

    // Called just after a posedge; returns one cycle into DONE with start_EX still high.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        exp_q.push_back(model(op, a, b));
        start_EX    = 1'b1;
        mdOp_EX     = op;
        operandA_EX = a;
        operandB_EX = b;
        #1;
        check("start_busy", {31'h0, busy}, 32'h0);
        n = 0;
        while (stall_md === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n < WIDTH + 2) begin
                mdOp_EX     = 2'($urandom);
                operandA_EX = $urandom;
                operandB_EX = $urandom;
            end
        end
        check("stall_cycles", n, WIDTH + 2);
        check("done_busy", {31'h0, busy}, 32'h1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0;
            3:       return 32'(($urandom_range(0, 40)));
            4:       return 32'h0 - 32'($urandom_range(1, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int gap;
        reset       = 1'b1;
        start_EX    = 1'b0;
        mdOp_EX     = 2'b00;
        operandA_EX = '0;
        operandB_EX = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_stall", {31'h0, stall_md}, 32'h0);
        next_cycle();

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        next_cycle();
        start_EX = 1'b0;
        next_cycle();
        run_op(2'b00, 32'hFFFF_FFF9, 32'd3);
        next_cycle();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        next_cycle();
        run_op(2'b11, 32'd100, 32'd0);
        next_cycle();
        run_op(2'b11, 32'd100, 32'd7);
        next_cycle();
        run_op(2'b10, 32'd100, 32'd0);
        next_cycle();
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        next_cycle();
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
        next_cycle();
        run_op(2'b01, 32'd6, 32'd7);
        next_cycle();
        run_op(2'b11, 32'd50, 32'd8);
        next_cycle();
        start_EX = 1'b0;
        next_cycle();

        // Abort an op mid-CALC.
        start_EX    = 1'b1;
        mdOp_EX     = 2'b01;
        operandA_EX = 32'd1234;
        operandB_EX = 32'd5678;
        repeat (10) next_cycle();
        reset    = 1'b1;
        start_EX = 1'b0;
        next_cycle();
        reset = 1'b0;
        check("abort_stall", {31'h0, stall_md}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        next_cycle();
        run_op(2'b01, 32'd3, 32'd5);
        next_cycle();
        start_EX = 1'b0;
        next_cycle();

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick());
            next_cycle();
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                start_EX = 1'b0;
                repeat (gap) next_cycle();
            end
        end
        start_EX = 1'b0;
        repeat (4) next_cycle();
        check("queue_drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Iterative multiply/divide unit with its own sequencing FSM; sits beside the EX-stage ALU.
- Owns the HI/LO registers and holds the pipeline while an iterative operation runs.
- Operands are the forwarded values leaving the EX forwarding muxes, so forwarding is already resolved.
- Stall output feeds the hazard unit, which freezes PC, IF/ID and ID/EX, and bubbles EX/MEM.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start_EX  input  1  EX-stage instruction is mult/multu/div/divu
mdOp_EX  input  2  00 mult, 01 multu, 10 div, 11 divu
operandA_EX  input  WIDTH  forwarded rs value (multiplicand/dividend)
operandB_EX  input  WIDTH  forwarded rt value (multiplier/divisor)
stall_md  output  1  hold pipeline (combinational)
busy  output  1  FSM not in IDLE (registered)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
divByZero  output  1  one-cycle pulse in DONE when the finished op was a divide with operandB_EX==0

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous, active-high, and has priority over everything.
- Reset values: state=IDLE; hi, lo, divByZero and busy = 0. The internal shift, accumulator and counter registers are also cleared.
- States: IDLE, CALC, FIX, DONE.
  - IDLE: if start_EX=1, latch mdOp_EX, operand magnitudes, sign flags, and the zero-divisor flag; counter=0; go to CALC. Otherwise stay.
  - CALC: exactly WIDTH cycles. Each cycle performs one shift-add step (multiply) or one restoring shift-subtract step (divide) on unsigned magnitudes. Counter increments each cycle; when counter==WIDTH-1, go to FIX.
  - FIX: one cycle. Apply sign correction and write hi/lo at the end of this cycle. Go to DONE.
  - DONE: one cycle; go to IDLE. start_EX is ignored here, because it is the same instruction now leaving EX.
- stall_md = (state==IDLE & start_EX) | state==CALC | state==FIX.
  - High for exactly WIDTH+2 consecutive cycles per op; low in DONE.
- Latency: start_EX seen in IDLE at cycle 0 → new hi/lo visible from cycle WIDTH+2 (the DONE cycle) onward.
- Back-to-back operations: a second md op enters EX at cycle WIDTH+3 with state=IDLE and starts normally. There are no dead cycles beyond DONE.
- Magnitude conversion:
  - Signed ops (mult, div) take two's-complement magnitude of negative operands.
  - Unsigned ops use the operands as-is.
- Multiply result: full 2·WIDTH-bit product. hi = upper WIDTH bits, lo = lower WIDTH bits.
  - Negate the 2·WIDTH-bit product in FIX if signed and signA≠signB.
- Divide result: lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero and is negated if signA≠signB. Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) → lo=0x80000000, hi=0. This is the natural magnitude result; no trap.
- Divide by zero (div or divu):
  - lo=0xFFFFFFFF, hi=operandA_EX as latched at start, with no sign correction.
  - divByZero pulses in DONE.
- hi/lo hold between operations and change only in FIX or on reset.
- Reset during CALC or FIX: the next cycle is IDLE with hi/lo=0 and the partial result discarded. stall_md falls the cycle after reset is sampled, unless start_EX is high then.
- mdOp_EX and operand changes after the start cycle are ignored.

Test Plan:
- Reset, then multu 0xFFFFFFFF × 0xFFFFFFFF → stall_md high cycles 0..33, low at 34; hi=0xFFFFFFFE, lo=0x00000001 in DONE; busy high cycles 1..34.
- mult -7 × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; div -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 100 / 0 → lo=0xFFFFFFFF, hi=100, divByZero high for exactly the DONE cycle; then divu 100/7 → lo=14, hi=2, divByZero stays 0.
- div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0; mult 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- Back-to-back: multu 6×7 then divu 50/8 with start_EX held across the DONE cycle → one op per instruction, the second starting at cycle 35; lo=42 then lo=6, hi=2.
- Assert reset at cycle 10 of a CALC → state IDLE, hi=lo=0, stall_md low next cycle; a fresh multu 3×5 then yields lo=15.
